// File: rtl/store_to_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// store_to_fetch_arbiter
//
// Shares the single-entry store->fetch mailbox between NUM_REQ store-side
// requesters (store lanes, exception/redirect unit). A round-robin arbiter
// fills one holding register. The fetch stage drains it with a valid/pop
// handshake. No requester can overwrite an unread packet, and a pop on an
// empty mailbox is recorded in a sticky error flag.
//
// Parameters
//   NUM_REQ  number of requesters (1..8)
//   PKT_W    packet width in bits
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          asynchronous, active-high reset
//   req_valid      [NUM_REQ]        requester i holds a packet
//   req_data       [NUM_REQ*PKT_W]  packet of requester i at [i*PKT_W +: PKT_W]
//   req_ready      [NUM_REQ]        one-hot grant: packet i accepted this cycle
//   fetch_valid    mailbox full
//   fetch_data     [PKT_W]          mailbox contents
//   fetch_pop      fetch consumes the mailbox this cycle
//   flush          synchronous discard of the mailbox contents
//   err_pop_empty  sticky: fetch_pop seen while the mailbox was empty
//
// Optional feature (macro STORE_TO_FETCH_ARB_STATS_EN):
//   stat_grants    [NUM_REQ*16]     per-requester grant count, saturating
//   stat_stalls    [16]             cycles with a pending request and no
//                                   grant, saturating
//   Both counters reset to 0. Flush does not clear them.
// -----------------------------------------------------------------------------
module store_to_fetch_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PKT_W   = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*PKT_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     fetch_valid,
   output logic [PKT_W-1:0]         fetch_data,
   input  logic                     fetch_pop,
   input  logic                     flush,
   output logic                     err_pop_empty
`ifdef STORE_TO_FETCH_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]    stat_grants,
   output logic [15:0]              stat_stalls
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [PKT_W-1:0]   data_reg, data_next;
   logic               err_reg, err_next;

   logic               space;
   logic               grant_found;
   logic               grant_en;
   logic [PTR_W-1:0]   grant_idx;
   logic [PKT_W-1:0]   grant_pkt;
   logic [PKT_W-1:0]   pkt_arr [NUM_REQ];
   int                 scan_idx;

   // Unpack the flat request bus so the winner can be selected by index.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign pkt_arr[gi]   = req_data[gi*PKT_W +: PKT_W];
         assign req_ready[gi] = grant_en && (grant_idx == PTR_W'(gi));
      end
   endgenerate

   // Round-robin search starting at rr_ptr_reg. The wrap is done by a
   // conditional subtract, which avoids a modulo for non power-of-two counts.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr_reg) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(scan_idx);
         end
      end
   end

   // A slot is free when the mailbox is empty or is being drained this
   // cycle. The free slot is what allows one packet per cycle back to back.
   assign space     = (state_reg == EMPTY) || fetch_pop;
   assign grant_en  = space && !flush && grant_found;
   assign grant_pkt = pkt_arr[grant_idx];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= EMPTY;
         rr_ptr_reg <= '0;
         data_reg   <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         data_reg   <= data_next;
         err_reg    <= err_next;
      end
   end

   // Next-state logic. Flush has priority: it blocks grants and swallows
   // any pop issued in the same cycle, so that pop cannot raise an error.
   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      data_next   = data_reg;
      err_next    = err_reg;
      if (flush) begin
         state_next = EMPTY;
      end else if (grant_en) begin
         state_next = FULL;
         data_next  = grant_pkt;
         if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
         end else begin
            rr_ptr_next = grant_idx + PTR_W'(1);
         end
      end else if (fetch_pop) begin
         case (state_reg)
            FULL:    state_next = EMPTY;
            default: err_next   = 1'b1;
         endcase
      end
   end

   assign fetch_valid   = (state_reg == FULL);
   assign fetch_data    = data_reg;
   assign err_pop_empty = err_reg;

`ifdef STORE_TO_FETCH_ARB_STATS_EN
   logic [15:0] stall_cnt_reg;

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
         logic [15:0] grant_cnt_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               grant_cnt_reg <= '0;
            end else if (req_ready[gi] && (grant_cnt_reg != 16'hFFFF)) begin
               grant_cnt_reg <= grant_cnt_reg + 16'd1;
            end
         end
         assign stat_grants[gi*16 +: 16] = grant_cnt_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if ((|req_valid) && !grant_en && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stat_stalls = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_store_to_fetch_arbiter.sv
module tb_store_to_fetch_arbiter;

   localparam int NUM_REQ = 3;
   localparam int PKT_W   = 64;

   logic                     clk;
   logic                     reset;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*PKT_W-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     fetch_valid;
   logic [PKT_W-1:0]         fetch_data;
   logic                     fetch_pop;
   logic                     flush;
   logic                     err_pop_empty;
`ifdef STORE_TO_FETCH_ARB_STATS_EN
   logic [NUM_REQ*16-1:0]    stat_grants;
   logic [15:0]              stat_stalls;
`endif

   int checks   = 0;
   int failures = 0;

   localparam logic [PKT_W-1:0] D0 = 64'h1111_0000_0000_00D0;
   localparam logic [PKT_W-1:0] D1 = 64'h2222_0000_0000_00D1;
   localparam logic [PKT_W-1:0] D2 = 64'h3333_0000_0000_00D2;

   store_to_fetch_arbiter #(.NUM_REQ(NUM_REQ), .PKT_W(PKT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fetch_valid   (fetch_valid),
      .fetch_data    (fetch_data),
      .fetch_pop     (fetch_pop),
      .flush         (flush),
      .err_pop_empty (err_pop_empty)
`ifdef STORE_TO_FETCH_ARB_STATS_EN
      ,
      .stat_grants   (stat_grants),
      .stat_stalls   (stat_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge. Combinational outputs are
   // sampled 2 ns later, and registered outputs 1 ns after the next edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      fetch_pop = 1'b0;
      flush     = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = '0;
      req_data  = {D2, D1, D0};
      fetch_pop = 1'b0;
      flush     = 1'b0;
      #12;
      checks++;
      if (fetch_valid !== 1'b0 || fetch_data !== '0 || err_pop_empty !== 1'b0 || req_ready !== 3'b000) begin
         failures++;
         $display("FAIL reset_state got v=%b d=%h e=%b r=%b exp v=0 d=0 e=0 r=000",
                  fetch_valid, fetch_data, err_pop_empty, req_ready);
      end
      next_cycle();
      reset = 1'b0;
      #2;
      checks++;
      if (req_ready !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle_ready got=%b exp=000", req_ready);
      end
      $display("txn reset done");
   endtask

   task automatic test_single();
      next_cycle();
      req_valid = 3'b001;
      req_data  = {D2, D1, 64'hA5};
      #2;
      checks++;
      if (req_ready !== 3'b001) begin
         failures++;
         $display("FAIL single_grant got=%b exp=001", req_ready);
      end
      next_cycle();
      req_valid = 3'b000;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== 64'hA5) begin
         failures++;
         $display("FAIL single_data got v=%b d=%h exp v=1 d=a5", fetch_valid, fetch_data);
      end
      $display("txn single grant req0 data=%h", fetch_data);
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] exp_grant [4];
      logic [PKT_W-1:0]   exp_data  [4];
      exp_grant[0] = 3'b001; exp_grant[1] = 3'b010;
      exp_grant[2] = 3'b100; exp_grant[3] = 3'b001;
      exp_data[1]  = D0;     exp_data[2]  = D1;     exp_data[3] = D2;
      exp_data[0]  = '0;
      do_reset();
      req_data  = {D2, D1, D0};
      req_valid = 3'b111;
      fetch_pop = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #2;
         checks++;
         if (req_ready !== exp_grant[c]) begin
            failures++;
            $display("FAIL rr_grant%0d got=%b exp=%b", c, req_ready, exp_grant[c]);
         end
         if (c > 0) begin
            checks++;
            if (fetch_valid !== 1'b1 || fetch_data !== exp_data[c]) begin
               failures++;
               $display("FAIL rr_data%0d got v=%b d=%h exp v=1 d=%h", c, fetch_valid, fetch_data, exp_data[c]);
            end
         end
         $display("txn rr cycle %0d grant=%b", c, req_ready);
         next_cycle();
         fetch_pop = (c < 3);
      end
      req_valid = 3'b000;
      fetch_pop = 1'b0;
      // The last grant (req0) left D0 in the mailbox and rr_ptr at 1.
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== D0) begin
         failures++;
         $display("FAIL rr_final got v=%b d=%h exp v=1 d=%h", fetch_valid, fetch_data, D0);
      end
   endtask

   task automatic test_full_stall();
      req_valid = 3'b010;
      for (int c = 0; c < 5; c++) begin
         #2;
         checks++;
         if (req_ready !== 3'b000 || fetch_data !== D0) begin
            failures++;
            $display("FAIL stall%0d got r=%b d=%h exp r=000 d=%h", c, req_ready, fetch_data, D0);
         end
         next_cycle();
      end
      fetch_pop = 1'b1;
      #2;
      checks++;
      if (req_ready !== 3'b010) begin
         failures++;
         $display("FAIL stall_pop_grant got=%b exp=010", req_ready);
      end
      next_cycle();
      req_valid = 3'b000;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== D1) begin
         failures++;
         $display("FAIL stall_new_data got v=%b d=%h exp v=1 d=%h", fetch_valid, fetch_data, D1);
      end
      $display("txn stall released grant req1");
      next_cycle();
      fetch_pop = 1'b0;
      checks++;
      if (fetch_valid !== 1'b0 || err_pop_empty !== 1'b0) begin
         failures++;
         $display("FAIL drain got v=%b e=%b exp v=0 e=0", fetch_valid, err_pop_empty);
      end
   endtask

   task automatic test_pop_empty();
      fetch_pop = 1'b1;
      next_cycle();
      fetch_pop = 1'b0;
      checks++;
      if (err_pop_empty !== 1'b1 || fetch_valid !== 1'b0) begin
         failures++;
         $display("FAIL pop_empty got e=%b v=%b exp e=1 v=0", err_pop_empty, fetch_valid);
      end
      next_cycle();
      next_cycle();
      checks++;
      if (err_pop_empty !== 1'b1) begin
         failures++;
         $display("FAIL pop_empty_sticky got=%b exp=1", err_pop_empty);
      end
      $display("txn pop on empty flagged");
   endtask

   task automatic test_flush();
      do_reset();
      req_valid = 3'b001;
      #2;
      checks++;
      if (req_ready !== 3'b001) begin
         failures++;
         $display("FAIL flush_fill got=%b exp=001", req_ready);
      end
      next_cycle();
      // FULL with D0. Flush together with a pop and a waiting req2.
      req_valid = 3'b100;
      flush     = 1'b1;
      fetch_pop = 1'b1;
      #2;
      checks++;
      if (req_ready !== 3'b000) begin
         failures++;
         $display("FAIL flush_no_grant got=%b exp=000", req_ready);
      end
      next_cycle();
      flush     = 1'b0;
      fetch_pop = 1'b0;
      checks++;
      if (fetch_valid !== 1'b0 || err_pop_empty !== 1'b0) begin
         failures++;
         $display("FAIL flush_empty got v=%b e=%b exp v=0 e=0", fetch_valid, err_pop_empty);
      end
      #2;
      checks++;
      if (req_ready !== 3'b100) begin
         failures++;
         $display("FAIL flush_after_grant got=%b exp=100", req_ready);
      end
      next_cycle();
      req_valid = 3'b000;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== D2) begin
         failures++;
         $display("FAIL flush_after_data got v=%b d=%h exp v=1 d=%h", fetch_valid, fetch_data, D2);
      end
      $display("txn flush then grant req2");
   endtask

   task automatic test_async_reset();
      // Drain the mailbox, then load req1 so that rr_ptr moves to 2.
      fetch_pop = 1'b1;
      next_cycle();
      fetch_pop = 1'b0;
      req_valid = 3'b010;
      next_cycle();
      req_valid = 3'b000;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== D1) begin
         failures++;
         $display("FAIL areset_pre got v=%b d=%h exp v=1 d=%h", fetch_valid, fetch_data, D1);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (fetch_valid !== 1'b0 || fetch_data !== '0) begin
         failures++;
         $display("FAIL areset_immediate got v=%b d=%h exp v=0 d=0", fetch_valid, fetch_data);
      end
      #1;
      reset = 1'b0;
      req_valid = 3'b111;
      #1;
      checks++;
      if (req_ready !== 3'b001) begin
         failures++;
         $display("FAIL areset_rr_ptr got=%b exp=001", req_ready);
      end
      $display("txn async reset mid-cycle");
      next_cycle();
      req_valid = 3'b000;
   endtask

`ifdef STORE_TO_FETCH_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req_valid = 3'b001;
      for (int c = 0; c < 70000; c++) begin
         next_cycle();
         fetch_pop = 1'b1;
      end
      req_valid = 3'b000;
      fetch_pop = 1'b0;
      checks++;
      if (stat_grants[15:0] !== 16'hFFFF) begin
         failures++;
         $display("FAIL stat_grants0 got=%h exp=ffff", stat_grants[15:0]);
      end
      $display("txn stats saturation grants0=%h", stat_grants[15:0]);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_pop_empty();
      test_flush();
      test_async_reset();
`ifdef STORE_TO_FETCH_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
